// File: rtl/gate_check_defs.sv
// gate_check_defs: shared FSM encoding and common 2-input truth tables for gate sweeps
package gate_check_defs;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_APPLY = 2'd1, S_DONE = 2'd2} state_t;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps all gate input vectors and checks y against a truth table
module gate_sweep_checker
  import gate_check_defs::*;
#(
  parameter int                  WIDTH       = 2,
  parameter int                  HOLD_CYCLES = 4,
  parameter logic [2**WIDTH-1:0] TRUTH       = TT_OR,
  parameter int                  ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] vec,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_vec
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_t        state, state_n;
  logic [HW-1:0] hold;
  logic          accept, last, term, mismatch;
  always_comb begin
    accept   = state == S_IDLE && start;
    last     = state == S_APPLY && hold == HW'(HOLD_CYCLES - 1);
    term     = vec == '1;
    mismatch = last && (y != TRUTH[vec]);
    state_n  = state == S_IDLE  ? (start ? S_APPLY : S_IDLE) :
               state == S_APPLY ? ((last && term) ? S_DONE : S_APPLY) : S_IDLE;
    busy     = state == S_APPLY;
    done     = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec        <= '0;
      hold       <= '0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (accept) begin
      vec        <= '0;
      hold       <= '0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (state == S_APPLY) begin
      hold <= last ? '0 : hold + 1'b1;
      if (last) vec <= term ? '0 : vec + 1'b1;
      // saturated count stays nonzero, so pass only needs the current sample too
      if (last && term) pass <= err_count == '0 && !mismatch;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_vec   <= vec;
      end
    end
  sat_counter #(.W(ERR_W)) u_err (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (mismatch),
    .q    (err_count)
  );
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: randomized gate behaviours checked against a truth-table model
module tb_gate_sweep_checker;
  import gate_check_defs::*;
  logic clk = 0, rst_n = 0, start = 0, start_f = 0;
  logic [3:0] gt = TT_OR;
  logic [1:0] vec_m, vec_a, vec_f, fvec_m, fvec_a, fvec_f;
  logic       busy_m, busy_a, busy_f, done_m, done_a, done_f, pass_m, pass_a, pass_f;
  logic       fv_m, fv_a, fv_f;
  logic [7:0] err_m, err_a;
  logic [0:0] err_f;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  gate_sweep_checker u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec_m), .y(gt[vec_m]), .busy(busy_m),
    .done(done_m), .pass(pass_m), .err_count(err_m), .fail_valid(fv_m), .fail_vec(fvec_m));
  gate_sweep_checker #(.TRUTH(TT_AND)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec_a), .y(gt[vec_a]), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .fail_valid(fv_a), .fail_vec(fvec_a));
  gate_sweep_checker #(.HOLD_CYCLES(1), .ERR_W(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f), .vec(vec_f), .y(gt[vec_f]), .busy(busy_f),
    .done(done_f), .pass(pass_f), .err_count(err_f), .fail_valid(fv_f), .fail_vec(fvec_f));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int n_mis(input logic [3:0] g, input logic [3:0] tt);
    n_mis = 0;
    for (int i = 0; i < 4; i++) if (g[i] != tt[i]) n_mis++;
  endfunction
  function automatic int first_mis(input logic [3:0] g, input logic [3:0] tt);
    first_mis = 0;
    for (int i = 3; i >= 0; i--) if (g[i] != tt[i]) first_mis = i;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic results(input string tag, input logic [31:0] err, input logic pass_o,
                         input logic fv, input logic [1:0] fvec, input logic [3:0] g,
                         input logic [3:0] tt, input int sat);
    int m;
    m = n_mis(g, tt);
    check({tag, "_err"}, err, m > sat ? sat : m);
    check({tag, "_pass"}, pass_o, m == 0);
    check({tag, "_fail_valid"}, fv, m != 0);
    check({tag, "_fail_vec"}, fvec, first_mis(g, tt));
  endtask
  task automatic sweep(input logic [3:0] g, input bit inject);
    int dm = 0, da = 0, df = 0;
    gt = g;
    start = 1; start_f = 1;
    tick();
    start = 0; start_f = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c <= 16) begin
        check("vec_m", vec_m, c < 16 ? c / 4 : 0);
        check("busy_m", busy_m, c < 16);
        check("busy_a", busy_a, c < 16);
      end
      if (c <= 4) begin
        check("vec_f", vec_f, c < 4 ? c : 0);
        check("busy_f", busy_f, c < 4);
      end
      check("done_m", done_m, c == 16);
      check("done_f", done_f, c == 4);
      if (c == 16) check("pass_at_done", pass_m, n_mis(g, TT_OR) == 0);
      dm += int'(done_m); da += int'(done_a); df += int'(done_f);
      if (inject && (c == 4 || c == 8 || c == 16)) start = 1;
      tick();
      start = 0;
    end
    check("done_pulses_m", dm, 1);
    check("done_pulses_a", da, 1);
    check("done_pulses_f", df, 1);
    results("main", err_m, pass_m, fv_m, fvec_m, g, TT_OR, 255);
    results("and", err_a, pass_a, fv_a, fvec_a, g, TT_AND, 255);
    results("fast", err_f, pass_f, fv_f, fvec_f, g, TT_OR, 1);
  endtask
  task automatic check_idle_zero(input string tag);
    check({tag, "_vec"}, vec_m, 0);
    check({tag, "_busy"}, busy_m, 0);
    check({tag, "_done"}, done_m, 0);
    check({tag, "_pass"}, pass_m, 0);
    check({tag, "_err"}, err_m, 0);
    check({tag, "_fail_valid"}, fv_m, 0);
    check({tag, "_fail_vec"}, fvec_m, 0);
  endtask
  initial begin
    tick();
    check_idle_zero("reset");
    tick();
    rst_n = 1;
    tick();
    sweep(TT_OR, 0);
    sweep(4'b0000, 0);
    sweep(TT_OR, 1);
    for (int k = 0; k < 8; k++) sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    gt = TT_OR;
    start = 1; start_f = 1;
    tick();
    start = 0; start_f = 0;
    repeat (8) tick();
    check("pre_abort_vec", vec_m, 2);
    rst_n = 0;
    #1;
    check_idle_zero("abort");
    for (int c = 0; c < 3; c++) begin
      tick();
      check("abort_done", done_m, 0);
      check("abort_busy", busy_m, 0);
    end
    rst_n = 1;
    tick();
    check("post_abort_idle", busy_m, 0);
    sweep(TT_OR, 0);
    sweep(4'b0000, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
